// File: rtl/sr_latch_writer.sv
// Write controller for a gated SR latch: drives set/reset around a timed enable strobe,
// then checks the synchronised q/q_ readback against the value written.
module sr_latch_writer #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int CNT_W         = 4
) (
    input  logic clock,
    input  logic reset_,
    input  logic write_request,
    input  logic write_value,
    input  logic latch_q,
    input  logic latch_q_,
    output logic latch_enable,
    output logic latch_set,
    output logic latch_reset,
    output logic busy,
    output logic done,
    output logic error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        CHECK  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             value;
    logic             q_sync_p0;
    logic             q_sync_p1;
    logic             qn_sync_p0;
    logic             qn_sync_p1;

    function automatic logic readback_bad(input logic q, input logic qn, input logic v);
        return !((q == v) && (qn == ~v));
    endfunction

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state        <= IDLE;
            count        <= '0;
            value        <= 1'b0;
            q_sync_p0    <= 1'b0;
            q_sync_p1    <= 1'b0;
            qn_sync_p0   <= 1'b0;
            qn_sync_p1   <= 1'b0;
            latch_enable <= 1'b0;
            latch_set    <= 1'b0;
            latch_reset  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            // readback synchroniser stage p0 -> p1
            q_sync_p0  <= latch_q;
            q_sync_p1  <= q_sync_p0;
            qn_sync_p0 <= latch_q_;
            qn_sync_p1 <= qn_sync_p0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (write_request) begin
                        value       <= write_value;
                        latch_set   <= write_value;
                        latch_reset <= ~write_value;
                        busy        <= 1'b1;
                        error       <= 1'b0;
                        count       <= SETUP_LOAD;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    if (count == '0) begin
                        latch_enable <= 1'b1;
                        count        <= STROBE_LOAD;
                        state        <= STROBE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                STROBE: begin
                    if (count == '0) begin
                        latch_enable <= 1'b0;
                        count        <= HOLD_LOAD;
                        state        <= HOLD;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                HOLD: begin
                    if (count == '0) begin
                        latch_set   <= 1'b0;
                        latch_reset <= 1'b0;
                        state       <= CHECK;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                CHECK: begin
                    // the p1 flops already reflect the strobe: hold + check spans the sync delay
                    error <= readback_bad(q_sync_p1, qn_sync_p1, value);
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    latch_enable <= 1'b0;
                    latch_set    <= 1'b0;
                    latch_reset  <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_writer.sv
// Scoreboard bench for sr_latch_writer driving a behavioural gated SR latch.
module tb_sr_latch_writer;

    logic clock = 1'b0;
    logic reset_ = 1'b0;
    logic write_request = 1'b0;
    logic write_value = 1'b0;
    logic latch_q;
    logic latch_q_;
    logic latch_enable;
    logic latch_set;
    logic latch_reset;
    logic busy;
    logic done;
    logic error;

    sr_latch_writer dut (
        .clock         (clock),
        .reset_        (reset_),
        .write_request (write_request),
        .write_value   (write_value),
        .latch_q       (latch_q),
        .latch_q_      (latch_q_),
        .latch_enable  (latch_enable),
        .latch_set     (latch_set),
        .latch_reset   (latch_reset),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    always #5 clock = ~clock;

    // behavioural gated SR latch, optionally stuck at 0
    logic lq = 1'b0;
    bit   stuck = 1'b0;
    always @(latch_enable or latch_set or latch_reset or stuck) begin
        if (stuck)
            lq = 1'b0;
        else if (latch_enable && latch_set && !latch_reset)
            lq = 1'b1;
        else if (latch_enable && latch_reset && !latch_set)
            lq = 1'b0;
    end
    assign latch_q  = lq;
    assign latch_q_ = ~lq;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic busy_d = 1'b0;
    bit   exp_err_q[$];
    int   accept_t[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: invariants every cycle, scoreboard pop on every done
    always @(negedge clock) begin
        cyc++;
        if (reset_) begin
            check("set_and_reset_both_high", int'(latch_set & latch_reset), 0);
            if (latch_enable)
                check("enable_without_single_drive", int'(latch_set ^ latch_reset), 1);
            if (busy && !busy_d)
                accept_t.push_back(cyc);
            if (done) begin
                check("busy_low_with_done", int'(busy), 0);
                if (exp_err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending write (cycle %0d)", cyc);
                end else begin
                    check("done_error", int'(error), int'(exp_err_q.pop_front()));
                end
            end
        end
        busy_d = busy;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout_busy", int'(busy), 0);
    endtask

    // returns at the negedge just after the accept edge
    task automatic issue(input logic v, input bit exp_err);
        @(negedge clock);
        write_request = 1'b1;
        write_value   = v;
        exp_err_q.push_back(exp_err);
        @(negedge clock);
        write_request = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        // Test 1: reset state, then reset asserted mid-strobe
        #1;
        check("rst_enable", int'(latch_enable), 0);
        check("rst_set", int'(latch_set), 0);
        check("rst_reset", int'(latch_reset), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        issue(1'b1, 1'b0);
        @(negedge clock);
        check("midwrite_enable_before_reset", int'(latch_enable), 1);
        #2 reset_ = 1'b0;
        #1;
        check("async_rst_enable", int'(latch_enable), 0);
        check("async_rst_set", int'(latch_set), 0);
        check("async_rst_reset", int'(latch_reset), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_error", int'(error), 0);
        exp_err_q.delete();
        repeat (2) @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_error", int'(error), 0);
        check("post_rst_done", int'(done), 0);

        // Test 2: write 1, cycle-by-cycle profile
        issue(1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            check($sformatf("w1_set_c%0d", i), int'(latch_set), (i <= 4) ? 1 : 0);
            check($sformatf("w1_reset_c%0d", i), int'(latch_reset), 0);
            check($sformatf("w1_enable_c%0d", i), int'(latch_enable), (i == 2 || i == 3) ? 1 : 0);
            check($sformatf("w1_busy_c%0d", i), int'(busy), (i <= 5) ? 1 : 0);
            check($sformatf("w1_done_c%0d", i), int'(done), (i == 6) ? 1 : 0);
            if (i < 6) @(negedge clock);
        end
        check("w1_latch_state", int'(lq), 1);

        // Test 3: write 0 after 1
        issue(1'b0, 1'b0);
        check("w0_reset_c1", int'(latch_reset), 1);
        check("w0_set_c1", int'(latch_set), 0);
        @(negedge clock);
        check("w0_enable_c2", int'(latch_enable), 1);
        check("w0_reset_c2", int'(latch_reset), 1);
        wait_idle();
        check("w0_latch_state", int'(lq), 0);

        // Test 4: stuck latch flags error; next accept clears it
        stuck = 1'b1;
        issue(1'b1, 1'b1);
        wait_idle();
        check("stuck_error_with_done", int'(error), 1);
        @(negedge clock);
        check("stuck_error_sticky", int'(error), 1);
        stuck = 1'b0;
        issue(1'b0, 1'b0);
        check("error_cleared_on_accept", int'(error), 0);
        wait_idle();

        // Test 5: request held for 20 cycles -> accepts every 6 cycles
        @(negedge clock);
        base = accept_t.size();
        write_request = 1'b1;
        write_value   = 1'b1;
        repeat (4) exp_err_q.push_back(1'b0);
        repeat (20) @(negedge clock);
        write_request = 1'b0;
        wait_idle();
        check("held_accept_count", accept_t.size() - base, 4);
        for (int k = base + 1; k < accept_t.size(); k++)
            check($sformatf("held_accept_spacing_%0d", k - base), accept_t[k] - accept_t[k-1], 6);

        // Test 6: request and value toggles while busy are ignored
        @(negedge clock);
        base = accept_t.size();
        issue(1'b0, 1'b0);
        repeat (2) @(negedge clock);
        write_request = 1'b1;
        write_value   = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
        check("busy_req_set_unchanged", int'(latch_set), 0);
        check("busy_req_reset_unchanged", int'(latch_reset), 1);
        write_value = 1'b0;
        wait_idle();
        repeat (3) @(negedge clock);
        check("busy_req_not_queued", int'(busy), 0);
        check("busy_req_accepts", accept_t.size() - base, 1);
        check("busy_req_latch_state", int'(lq), 0);
        check("scoreboard_drained", exp_err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
